// File: rtl/m_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS controller: state codes, opcode and
// funct values, ALU operation codes, datapath mux selects, the per-state control
// word and the helpers that decode it.
package m_ctrl_fsm_pkg;

  // 5-bit state codes; state_out exposes these for the debug display.
  typedef enum logic [4:0] {
    S_IF  = 5'd0,
    S_ID  = 5'd1,
    S_MA  = 5'd2,
    S_MR  = 5'd3,
    S_LWB = 5'd4,
    S_MW  = 5'd5,
    S_RX  = 5'd6,
    S_RWB = 5'd7,
    S_IX  = 5'd8,
    S_IWB = 5'd9,
    S_BEQ = 5'd10,
    S_BNE = 5'd11,
    S_J   = 5'd12,
    S_JAL = 5'd13,
    S_JR  = 5'd14,
    S_LUI = 5'd15
  } state_t;

  // Primary opcodes (Inst[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (Inst[5:0]).
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // ALU operation codes understood by the datapath ALU.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  // Datapath mux selects.
  localparam logic [1:0] REGDST_RT     = 2'd0;
  localparam logic [1:0] REGDST_RD     = 2'd1;
  localparam logic [1:0] REGDST_R31    = 2'd2;
  localparam logic [1:0] MEM2REG_ALU   = 2'd0;
  localparam logic [1:0] MEM2REG_MDR   = 2'd1;
  localparam logic [1:0] MEM2REG_LUI   = 2'd2;
  localparam logic [1:0] MEM2REG_PC    = 2'd3;
  localparam logic [1:0] SRCB_RT       = 2'd0;
  localparam logic [1:0] SRCB_FOUR     = 2'd1;
  localparam logic [1:0] SRCB_IMM      = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2  = 2'd3;
  localparam logic [1:0] PCSRC_ALU     = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'd1;
  localparam logic [1:0] PCSRC_JUMP    = 2'd2;

  // Moore part of the control word; the input-dependent terms are added in the top.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
  } ctrl_t;

  // Control word asserted while the FSM sits in state s; dec_op is the decoded
  // ALU operation used by the RX/IX execute states.
  function automatic ctrl_t state_ctrl(state_t s, logic [3:0] dec_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_write  = 1'b1;
      end
      S_ID: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
      end
      S_MA: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MR: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_LWB: begin
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = MEM2REG_MDR;
        c.reg_write  = 1'b1;
      end
      S_MW: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_RX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = dec_op;
      end
      S_RWB: begin
        c.reg_dst   = REGDST_RD;
        c.reg_write = 1'b1;
      end
      S_IX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = dec_op;
      end
      S_IWB: begin
        c.reg_dst   = REGDST_RT;
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALU_SUB;
        c.pc_source     = PCSRC_ALUOUT;
        c.pc_write_cond = 1'b1;
        c.branch        = 1'b1;
      end
      S_BNE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_SUB;
        c.pc_source = PCSRC_ALUOUT;
      end
      S_J: begin
        c.pc_source = PCSRC_JUMP;
        c.pc_write  = 1'b1;
      end
      S_JAL: begin
        c.pc_source  = PCSRC_JUMP;
        c.pc_write   = 1'b1;
        c.reg_dst    = REGDST_R31;
        c.mem_to_reg = MEM2REG_PC;
        c.reg_write  = 1'b1;
      end
      S_JR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCSRC_ALU;
        c.pc_write  = 1'b1;
      end
      S_LUI: begin
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = MEM2REG_LUI;
        c.reg_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instructions whose signed overflow may suppress the result write.
  function automatic logic is_trap_instr(logic [5:0] opcode, logic [5:0] funct);
    return ((opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB))) ||
           (opcode == OP_ADDI);
  endfunction

endpackage

// File: rtl/m_ctrl_fsm_if.sv
// Controller <-> datapath bus: instruction and ALU flags in, control strobes and
// mux selects out. master = controller side, slave = datapath side.
interface m_ctrl_fsm_if;
  logic [31:0] Inst;
  logic        zero;
  logic        overflow;
  logic        MIO_ready;

  logic        MemRead;
  logic        MemWrite;
  logic        CPU_MIO;
  logic        IorD;
  logic        IRWrite;
  logic        RegWrite;
  logic        ALUSrcA;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic [3:0]  ALU_operation;
  logic        ovf_trap;
  logic [4:0]  state_out;

  modport master (
    input  Inst, zero, overflow, MIO_ready,
    output MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA,
           PCWrite, PCWriteCond, Branch, RegDst, MemtoReg, ALUSrcB, PCSource,
           ALU_operation, ovf_trap, state_out
  );

  modport slave (
    output Inst, zero, overflow, MIO_ready,
    input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA,
           PCWrite, PCWriteCond, Branch, RegDst, MemtoReg, ALUSrcB, PCSource,
           ALU_operation, ovf_trap, state_out
  );
endinterface

// File: rtl/m_alu_dec.sv
// ALU operation decoder: maps {opcode, funct} of an R-type or ALU-immediate
// instruction to the ALU operation code; valid_o is low for anything else.
module m_alu_dec
  import m_ctrl_fsm_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       valid_o
);

  // Pure lookup; R-type selects on funct, immediates on the opcode.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs (no latches).
    alu_op_o = ALU_AND;
    valid_o  = 1'b1;
    if (opcode_i == OP_RTYPE) begin
      case (funct_i)
        FN_ADD:  alu_op_o = ALU_ADD;
        FN_SUB:  alu_op_o = ALU_SUB;
        FN_AND:  alu_op_o = ALU_AND;
        FN_OR:   alu_op_o = ALU_OR;
        FN_XOR:  alu_op_o = ALU_XOR;
        FN_NOR:  alu_op_o = ALU_NOR;
        FN_SLT:  alu_op_o = ALU_SLT;
        FN_SRL:  alu_op_o = ALU_SRL;
        FN_SLL:  alu_op_o = ALU_SLL;
        default: valid_o  = 1'b0;
      endcase
    end else begin
      case (opcode_i)
        OP_ADDI: alu_op_o = ALU_ADD;
        OP_ANDI: alu_op_o = ALU_AND;
        OP_ORI:  alu_op_o = ALU_OR;
        OP_XORI: alu_op_o = ALU_XOR;
        OP_SLTI: alu_op_o = ALU_SLT;
        default: valid_o  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/m_ctrl_fsm.sv
// Multicycle MIPS controller driving M_datapath. Moore FSM whose control word is
// registered alongside the state (decoded from the next state); the only
// input-dependent outputs are IRWrite (gated by MIO_ready in IF) and PCWrite in
// BNE (taken when zero is low). All outputs read 0 while reset_n is low.
// Optional feature: define M_CTRL_OVF_TRAP_EN to suppress the register write of
// an overflowing add/sub/addi and pulse ovf_trap for that write-back cycle.
module m_ctrl_fsm
  import m_ctrl_fsm_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  m_ctrl_fsm_if.master  bus
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] dec_op;
  logic       dec_valid;
  logic       trap;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  assign opcode = bus.Inst[31:26];
  assign funct  = bus.Inst[5:0];

  m_alu_dec u_alu_dec (
    .opcode_i (opcode),
    .funct_i  (funct),
    .alu_op_o (dec_op),
    .valid_o  (dec_valid)
  );

  // Next-state logic: dispatch in ID, stall only in IF/MR/MW.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: if (bus.MIO_ready) state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MA;
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_RX;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_J:         state_d = S_J;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_IX;
          default:      state_d = S_IF;
        endcase
      end
      S_MA:    state_d = (opcode == OP_LW) ? S_MR : S_MW;
      S_MR:    if (bus.MIO_ready) state_d = S_LWB;
      S_MW:    if (bus.MIO_ready) state_d = S_IF;
      S_RX:    state_d = dec_valid ? S_RWB : S_IF;
      S_IX:    state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  // The control word is decoded for the state being entered so it lines up
  // with state_q; Inst is already stable in ID, so RX/IX get the right ALU op.
  assign ctrl_d = state_ctrl(state_d, dec_op);

`ifdef M_CTRL_OVF_TRAP_EN
  logic ovf_q;

  // State, registered control word and the overflow flag captured at execute.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      ctrl_q  <= state_ctrl(S_IF, ALU_ADD);
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if ((state_q == S_RX) || (state_q == S_IX)) ovf_q <= bus.overflow;
    end
  end

  assign trap = ovf_q && ((state_q == S_RWB) || (state_q == S_IWB)) &&
                is_trap_instr(opcode, funct);
`else
  // State and registered control word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      ctrl_q  <= state_ctrl(S_IF, ALU_ADD);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign trap = 1'b0;
`endif

  // Outputs are forced low while reset is held, so an interrupted access or a
  // pending write-back is never issued; the register keeps the IF word ready.
  assign bus.MemRead       = reset_n & ctrl_q.mem_read;
  assign bus.MemWrite      = reset_n & ctrl_q.mem_write;
  assign bus.CPU_MIO       = bus.MemRead | bus.MemWrite;
  assign bus.IorD          = reset_n & ctrl_q.iord;
  assign bus.IRWrite       = reset_n & (state_q == S_IF) & bus.MIO_ready;
  assign bus.RegWrite      = reset_n & ctrl_q.reg_write & ~trap;
  assign bus.ALUSrcA       = reset_n & ctrl_q.alu_src_a;
  assign bus.PCWrite       = reset_n & (ctrl_q.pc_write | ((state_q == S_BNE) & ~bus.zero));
  assign bus.PCWriteCond   = reset_n & ctrl_q.pc_write_cond;
  assign bus.Branch        = reset_n & ctrl_q.branch;
  assign bus.RegDst        = {2{reset_n}} & ctrl_q.reg_dst;
  assign bus.MemtoReg      = {2{reset_n}} & ctrl_q.mem_to_reg;
  assign bus.ALUSrcB       = {2{reset_n}} & ctrl_q.alu_src_b;
  assign bus.PCSource      = {2{reset_n}} & ctrl_q.pc_source;
  assign bus.ALU_operation = {4{reset_n}} & ctrl_q.alu_op;
  assign bus.ovf_trap      = reset_n & trap;
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_m_ctrl_fsm.sv
// Directed bench for m_ctrl_fsm. Inputs change on the falling edge and outputs
// are sampled 1 time unit later, mid-cycle, so each check sees one FSM state.
module tb_m_ctrl_fsm;
  import m_ctrl_fsm_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  m_ctrl_fsm_if bus ();

  m_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // IF cycle with memory ready: loads the instruction and moves to ID.
  task automatic fetch(input logic [31:0] inst);
    bus.Inst = inst;
    bus.MIO_ready = 1'b1;
    #1;
    checks++;
    if (bus.state_out !== S_IF || bus.IRWrite !== 1'b1) begin
      errors++;
      $display("FAIL fetch_if: state=%0d IRWrite=%b want state=%0d IRWrite=1", bus.state_out, bus.IRWrite, S_IF);
    end
    @(negedge clk);
    bus.MIO_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] snap;
    snap = {bus.MemRead, bus.MemWrite, bus.CPU_MIO, bus.IorD, bus.IRWrite, bus.RegWrite,
            bus.ALUSrcA, bus.PCWrite, bus.PCWriteCond, bus.Branch, bus.ovf_trap,
            bus.RegDst, bus.MemtoReg, bus.ALUSrcB, bus.PCSource, bus.ALU_operation, bus.state_out};
    checks++;
    if (snap !== 28'h0) begin errors++; $display("FAIL reset_outs: got %h want 0", snap); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.state_out !== S_IF || bus.MemRead !== 1'b1 || bus.CPU_MIO !== 1'b1 ||
        bus.PCWrite !== 1'b1 || bus.ALUSrcB !== 2'd1 || bus.ALU_operation !== 4'b0010 || bus.IRWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d MemRead=%b CPU_MIO=%b PCWrite=%b ALUSrcB=%0d op=%b IRWrite=%b",
               bus.state_out, bus.MemRead, bus.CPU_MIO, bus.PCWrite, bus.ALUSrcB, bus.ALU_operation, bus.IRWrite);
    end
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_IF) begin errors++; $display("FAIL if_stall: state=%0d want %0d", bus.state_out, S_IF); end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02, 6'h00};
    logic [3:0] ops [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0111, 4'b0101, 4'b1000};
    // add $3,$1,$2 walked state by state.
    fetch(32'h00221820);
    checks++;
    if (bus.state_out !== S_ID || bus.ALUSrcB !== 2'd3 || bus.ALU_operation !== 4'b0010 || bus.ALUSrcA !== 1'b0) begin
      errors++;
      $display("FAIL id_state: state=%0d ALUSrcB=%0d op=%b ALUSrcA=%b", bus.state_out, bus.ALUSrcB, bus.ALU_operation, bus.ALUSrcA);
    end
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_RX || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'd0 || bus.ALU_operation !== 4'b0010) begin
      errors++;
      $display("FAIL rx_add: state=%0d ALUSrcA=%b ALUSrcB=%0d op=%b", bus.state_out, bus.ALUSrcA, bus.ALUSrcB, bus.ALU_operation);
    end
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_RWB || bus.RegDst !== 2'd1 || bus.RegWrite !== 1'b1 || bus.MemtoReg !== 2'd0 || bus.ovf_trap !== 1'b0) begin
      errors++;
      $display("FAIL rwb_add: state=%0d RegDst=%0d RegWrite=%b MemtoReg=%0d trap=%b",
               bus.state_out, bus.RegDst, bus.RegWrite, bus.MemtoReg, bus.ovf_trap);
    end
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_IF) begin errors++; $display("FAIL rwb_to_if: state=%0d want %0d", bus.state_out, S_IF); end
    // Every supported funct: ALU op in RX, then a write-back.
    for (int i = 0; i < 9; i++) begin
      fetch({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn[i]});
      @(negedge clk);
      checks++;
      if (bus.state_out !== S_RX || bus.ALU_operation !== ops[i]) begin
        errors++;
        $display("FAIL rx_funct_%h: state=%0d op=%b want op=%b", fn[i], bus.state_out, bus.ALU_operation, ops[i]);
      end
      @(negedge clk);
      checks++;
      if (bus.state_out !== S_RWB || bus.RegWrite !== 1'b1) begin
        errors++;
        $display("FAIL rwb_funct_%h: state=%0d RegWrite=%b", fn[i], bus.state_out, bus.RegWrite);
      end
      @(negedge clk);
    end
    // Unknown funct (addu): RX then straight back to IF without a write.
    fetch(32'h00221821);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_IF || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL rx_bad_funct: state=%0d RegWrite=%b want state=%0d RegWrite=0", bus.state_out, bus.RegWrite, S_IF);
    end
  endtask

  task automatic test_lw();
    fetch(32'h8C040008);
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_MA || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'd2 || bus.ALU_operation !== 4'b0010) begin
      errors++;
      $display("FAIL ma_lw: state=%0d ALUSrcA=%b ALUSrcB=%0d op=%b", bus.state_out, bus.ALUSrcA, bus.ALUSrcB, bus.ALU_operation);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.MIO_ready = (i == 3);
      #1;
      checks++;
      if (bus.state_out !== S_MR || bus.MemRead !== 1'b1 || bus.IorD !== 1'b1 || bus.CPU_MIO !== 1'b1 || bus.IRWrite !== 1'b0) begin
        errors++;
        $display("FAIL mr_hold_%0d: state=%0d MemRead=%b IorD=%b CPU_MIO=%b IRWrite=%b",
                 i, bus.state_out, bus.MemRead, bus.IorD, bus.CPU_MIO, bus.IRWrite);
      end
      @(negedge clk);
    end
    bus.MIO_ready = 1'b0;
    checks++;
    if (bus.state_out !== S_LWB || bus.MemtoReg !== 2'd1 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'd0 || bus.MemRead !== 1'b0) begin
      errors++;
      $display("FAIL lwb: state=%0d MemtoReg=%0d RegWrite=%b RegDst=%0d MemRead=%b",
               bus.state_out, bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.MemRead);
    end
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_IF) begin errors++; $display("FAIL lwb_to_if: state=%0d want %0d", bus.state_out, S_IF); end
  endtask

  task automatic test_sw();
    fetch(32'hAC040008);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.state_out !== S_MW || bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0 || bus.CPU_MIO !== 1'b1 || bus.IorD !== 1'b1) begin
      errors++;
      $display("FAIL mw_stall: state=%0d MemWrite=%b MemRead=%b CPU_MIO=%b IorD=%b",
               bus.state_out, bus.MemWrite, bus.MemRead, bus.CPU_MIO, bus.IorD);
    end
    @(negedge clk);
    bus.MIO_ready = 1'b1;
    #1;
    checks++;
    if (bus.state_out !== S_MW) begin errors++; $display("FAIL mw_hold: state=%0d want %0d", bus.state_out, S_MW); end
    @(negedge clk);
    bus.MIO_ready = 1'b0;
    checks++;
    if (bus.state_out !== S_IF || bus.MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL mw_to_if: state=%0d MemWrite=%b", bus.state_out, bus.MemWrite);
    end
  endtask

  task automatic test_branch();
    fetch(32'h10220004);
    @(negedge clk);
    bus.zero = 1'b1;
    #1;
    checks++;
    if (bus.state_out !== S_BEQ || bus.PCWriteCond !== 1'b1 || bus.Branch !== 1'b1 || bus.PCSource !== 2'd1 ||
        bus.ALU_operation !== 4'b0110 || bus.PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL beq: state=%0d PCWriteCond=%b Branch=%b PCSource=%0d op=%b PCWrite=%b",
               bus.state_out, bus.PCWriteCond, bus.Branch, bus.PCSource, bus.ALU_operation, bus.PCWrite);
    end
    @(negedge clk);
    bus.zero = 1'b0;
    checks++;
    if (bus.state_out !== S_IF) begin errors++; $display("FAIL beq_to_if: state=%0d want %0d", bus.state_out, S_IF); end
    fetch(32'h14220004);
    @(negedge clk);
    #1;
    checks++;
    if (bus.state_out !== S_BNE || bus.PCWrite !== 1'b1 || bus.PCWriteCond !== 1'b0 || bus.Branch !== 1'b0 || bus.PCSource !== 2'd1) begin
      errors++;
      $display("FAIL bne_taken: state=%0d PCWrite=%b PCWriteCond=%b Branch=%b PCSource=%0d",
               bus.state_out, bus.PCWrite, bus.PCWriteCond, bus.Branch, bus.PCSource);
    end
    bus.zero = 1'b1;
    #1;
    checks++;
    if (bus.PCWrite !== 1'b0) begin errors++; $display("FAIL bne_not_taken: PCWrite=%b want 0", bus.PCWrite); end
    @(negedge clk);
    bus.zero = 1'b0;
    checks++;
    if (bus.state_out !== S_IF) begin errors++; $display("FAIL bne_to_if: state=%0d want %0d", bus.state_out, S_IF); end
  endtask

  task automatic test_jump();
    fetch(32'h0C000040);
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_JAL || bus.RegDst !== 2'd2 || bus.MemtoReg !== 2'd3 || bus.RegWrite !== 1'b1 ||
        bus.PCSource !== 2'd2 || bus.PCWrite !== 1'b1) begin
      errors++;
      $display("FAIL jal: state=%0d RegDst=%0d MemtoReg=%0d RegWrite=%b PCSource=%0d PCWrite=%b",
               bus.state_out, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.PCSource, bus.PCWrite);
    end
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_IF) begin errors++; $display("FAIL jal_to_if: state=%0d want %0d", bus.state_out, S_IF); end
    fetch(32'h08000040);
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_J || bus.PCWrite !== 1'b1 || bus.PCSource !== 2'd2 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL j: state=%0d PCWrite=%b PCSource=%0d RegWrite=%b", bus.state_out, bus.PCWrite, bus.PCSource, bus.RegWrite);
    end
    @(negedge clk);
    fetch(32'h03E00008);
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_JR || bus.PCWrite !== 1'b1 || bus.PCSource !== 2'd0 || bus.ALUSrcA !== 1'b1 ||
        bus.ALUSrcB !== 2'd0 || bus.ALU_operation !== 4'b0010) begin
      errors++;
      $display("FAIL jr: state=%0d PCWrite=%b PCSource=%0d ALUSrcA=%b ALUSrcB=%0d op=%b",
               bus.state_out, bus.PCWrite, bus.PCSource, bus.ALUSrcA, bus.ALUSrcB, bus.ALU_operation);
    end
    @(negedge clk);
    fetch(32'h3C011234);
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_LUI || bus.MemtoReg !== 2'd2 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'd0) begin
      errors++;
      $display("FAIL lui: state=%0d MemtoReg=%0d RegWrite=%b RegDst=%0d", bus.state_out, bus.MemtoReg, bus.RegWrite, bus.RegDst);
    end
    @(negedge clk);
    // Unsupported opcode behaves as a nop: ID then back to IF.
    fetch(32'hFC000000);
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_IF || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL bad_opcode: state=%0d RegWrite=%b want state=%0d", bus.state_out, bus.RegWrite, S_IF);
    end
  endtask

  task automatic test_ovf();
    logic exp_we, exp_trap;
`ifdef M_CTRL_OVF_TRAP_EN
    exp_we = 1'b0; exp_trap = 1'b1;
`else
    exp_we = 1'b1; exp_trap = 1'b0;
`endif
    // addi with overflow.
    fetch(32'h20220005);
    @(negedge clk);
    bus.overflow = 1'b1;
    #1;
    checks++;
    if (bus.state_out !== S_IX || bus.ALU_operation !== 4'b0010 || bus.ALUSrcB !== 2'd2 || bus.ALUSrcA !== 1'b1) begin
      errors++;
      $display("FAIL ix_addi: state=%0d op=%b ALUSrcB=%0d ALUSrcA=%b", bus.state_out, bus.ALU_operation, bus.ALUSrcB, bus.ALUSrcA);
    end
    @(negedge clk);
    bus.overflow = 1'b0;
    checks++;
    if (bus.state_out !== S_IWB || bus.RegWrite !== exp_we || bus.ovf_trap !== exp_trap || bus.RegDst !== 2'd0) begin
      errors++;
      $display("FAIL iwb_addi_ovf: state=%0d RegWrite=%b trap=%b RegDst=%0d want RegWrite=%b trap=%b",
               bus.state_out, bus.RegWrite, bus.ovf_trap, bus.RegDst, exp_we, exp_trap);
    end
    @(negedge clk);
    checks++;
    if (bus.ovf_trap !== 1'b0 || bus.state_out !== S_IF) begin
      errors++;
      $display("FAIL trap_pulse_end: trap=%b state=%0d", bus.ovf_trap, bus.state_out);
    end
    // andi never traps, even with overflow raised.
    fetch(32'h30220005);
    @(negedge clk);
    bus.overflow = 1'b1;
    #1;
    checks++;
    if (bus.ALU_operation !== 4'b0000) begin errors++; $display("FAIL ix_andi: op=%b want 0000", bus.ALU_operation); end
    @(negedge clk);
    bus.overflow = 1'b0;
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.ovf_trap !== 1'b0) begin
      errors++;
      $display("FAIL iwb_andi_ovf: RegWrite=%b trap=%b want 1 0", bus.RegWrite, bus.ovf_trap);
    end
    @(negedge clk);
    // R-type add with overflow.
    fetch(32'h00221820);
    @(negedge clk);
    bus.overflow = 1'b1;
    @(negedge clk);
    bus.overflow = 1'b0;
    checks++;
    if (bus.state_out !== S_RWB || bus.RegWrite !== exp_we || bus.ovf_trap !== exp_trap) begin
      errors++;
      $display("FAIL rwb_add_ovf: state=%0d RegWrite=%b trap=%b want RegWrite=%b trap=%b",
               bus.state_out, bus.RegWrite, bus.ovf_trap, exp_we, exp_trap);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mr();
    logic [27:0] snap;
    fetch(32'h8C040008);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.state_out !== S_MR) begin errors++; $display("FAIL mid_mr_enter: state=%0d want %0d", bus.state_out, S_MR); end
    reset_n = 1'b0;
    #1;
    snap = {bus.MemRead, bus.MemWrite, bus.CPU_MIO, bus.IorD, bus.IRWrite, bus.RegWrite,
            bus.ALUSrcA, bus.PCWrite, bus.PCWriteCond, bus.Branch, bus.ovf_trap,
            bus.RegDst, bus.MemtoReg, bus.ALUSrcB, bus.PCSource, bus.ALU_operation, bus.state_out};
    checks++;
    if (snap !== 28'h0) begin errors++; $display("FAIL mid_mr_reset: got %h want 0", snap); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.state_out !== S_IF || bus.MemRead !== 1'b1 || bus.IorD !== 1'b0 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_mr_release: state=%0d MemRead=%b IorD=%b RegWrite=%b", bus.state_out, bus.MemRead, bus.IorD, bus.RegWrite);
    end
    @(negedge clk);
    checks++;
    if (bus.state_out !== S_IF) begin errors++; $display("FAIL mid_mr_stay_if: state=%0d want %0d", bus.state_out, S_IF); end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.Inst      = 32'h0;
    bus.zero      = 1'b0;
    bus.overflow  = 1'b0;
    bus.MIO_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_ovf();
    test_reset_mid_mr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
